// File: rtl/wr_port_arbiter.sv
// wr_port_arbiter
// Round-robin arbiter that shares one register-file write port among four
// requesters. The grant is registered and presented two ways: a 2-bit index
// plus enable (drives a 2-to-4 decoder's in/en pins) and the equivalent
// one-hot vector. A requester may lock the grant for multi-cycle transfers,
// but only for MAX_HOLD consecutive cycles while others are waiting.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   req      in   4  level request per requester
//   lock     in   4  keep-grant request, only meaningful with matching req
//   gnt_idx  out  2  index of current owner (decoder in)
//   gnt_en   out  1  a grant is active (decoder en)
//   gnt      out  4  one-hot grant, zero when idle
//   hold_cnt out  4  consecutive cycles the owner has held the grant, 0 idle
module wr_port_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] lock,
    output logic [1:0] gnt_idx,
    output logic       gnt_en,
    output logic [3:0] gnt,
    output logic [3:0] hold_cnt
);

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;

    logic       new_grant;
    logic [1:0] new_idx;
    logic [1:0] owner;
    logic [1:0] owner_nxt;
    logic [3:0] others;
    logic [3:0] gnt_dec;

    // First set bit of r, searching base, base+1, base+2, base+3 (mod 4).
    // Walking the offsets downward lets the smallest offset win last.
    function automatic logic [1:0] rr_pick(input logic [1:0] base,
                                           input logic [3:0] r);
        logic [1:0] pick;
        pick = base;
        for (int k = 3; k >= 0; k--) begin
            if (r[base + 2'(k)]) begin
                pick = base + 2'(k);
            end
        end
        return pick;
    endfunction

    assign owner     = gnt_idx_q;
    assign owner_nxt = gnt_idx_q + 2'd1;
    assign others    = req & ~(4'b0001 << owner);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        hold_cnt_d = hold_cnt_q;
        new_grant  = 1'b0;
        new_idx    = 2'd0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    new_grant = 1'b1;
                    new_idx   = rr_pick(ptr_q, req);
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    // Owner released: hand over without an idle bubble.
                    if (|others) begin
                        new_grant = 1'b1;
                        new_idx   = rr_pick(owner_nxt, others);
                    end else begin
                        state_d    = IDLE;
                        hold_cnt_d = 4'd0;
                    end
                end else if (!lock[owner]) begin
                    // Single beat: owner competes last, re-granted only if alone.
                    new_grant = 1'b1;
                    new_idx   = rr_pick(owner_nxt, req);
                end else if (hold_cnt_q < MAX_HOLD_C) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end else if (|others) begin
                    // Lock budget exhausted and someone is waiting: rotate.
                    new_grant = 1'b1;
                    new_idx   = rr_pick(owner_nxt, others);
                end else begin
                    hold_cnt_d = MAX_HOLD_C;
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = 4'd0;
            end
        endcase

        if (new_grant) begin
            state_d    = GRANT;
            gnt_idx_d  = new_idx;
            ptr_d      = new_idx + 2'd1;
            hold_cnt_d = 4'd1;
        end
    end

    // One-hot view of the next index, gated to zero when going idle.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
        assign gnt_dec[gi] = (gnt_idx_d == 2'(gi));
    end
    assign gnt_d = (state_d == GRANT) ? gnt_dec : 4'b0000;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd0;
            gnt_idx_q  <= 2'd0;
            gnt_q      <= 4'b0000;
            hold_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_q      <= gnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt_idx  = gnt_idx_q;
    assign gnt_en   = (state_q == GRANT);
    assign gnt      = gnt_q;
    assign hold_cnt = hold_cnt_q;

endmodule
